// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word per request and presents it as inst until retired.
// Latency: imem_req rises 1 cycle after reset release and 1 cycle after each retire; inst_valid the cycle after imem_ready.
// Backpressure: imem_ready=0 holds the request with a stable address; stall=1 holds inst, pc and count in HOLD.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   imem_addr/req/rdata/ready        instruction memory request/response handshake
//   inst, inst_valid, pc_plus4       fetched word, its valid flag and its address plus 4
//   stall                            downstream hold request
//   pc_src, jump, jr, jr_target      next-PC selection, sampled on the retire edge only
//   retired_count                    number of retired instructions (wraps)
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        pc_src,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] retired_count
);

  // State bits double as the registered imem_req (bit 0) and inst_valid (bit 1).
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] inst_q;
  logic [31:0] count_q;
  logic [31:0] next_pc;
  logic [31:0] br_off;
  logic [31:0] jr_pc;
  logic        capture;
  logic        retire;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (imem_ready) state_nxt = HOLD;
      HOLD:    if (!stall) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; imem_ready is only honoured while a request is outstanding.
  always_comb begin
    imem_req   = state[0];
    inst_valid = state[1];
    capture    = state[0] & imem_ready;
    retire     = state[1] & ~stall;
  end

  assign imem_addr     = pc;
  assign pc_plus4      = pc + 32'd4;
  assign inst          = inst_q;
  assign retired_count = count_q;

  // Next PC: jr > jump > branch > sequential.
  assign br_off = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
  assign jr_pc  = jr_target & 32'hFFFF_FFFC;

  always_comb begin
    next_pc = pc_plus4;
    if (jr) begin
      next_pc = jr_pc;
    end else if (jump) begin
      next_pc = {pc_plus4[31:28], inst_q[25:0], 2'b00};
    end else if (pc_src) begin
      next_pc = pc_plus4 + br_off;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      inst_q  <= 32'd0;
      count_q <= 32'd0;
    end else begin
      if (capture) begin
        inst_q <= imem_rdata;
      end
      if (retire) begin
        pc      <= next_pc;
        count_q <= count_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: scoreboard of expected fetch addresses and instruction words.
// Main instance starts at 0x100 and walks sequential, JR, branch and jump retires, then async reset.
// A second instance starts at 0xFFFF_FFFC with a zero-wait memory to exercise PC wrap.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        pc_src;
  logic        jump;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] retired_count;

  logic        w_rst_n;
  logic [31:0] w_addr;
  logic        w_req;
  logic [31:0] w_inst;
  logic        w_valid;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_count;

  int total = 0;
  int bad   = 0;
  int retired = 0;
  logic [31:0] cur_pc;
  logic [31:0] cur_inst;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_inst_q[$];

  inst_fetch_unit #(.RESET_PC(32'h0000_0100)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .inst(inst), .inst_valid(inst_valid), .pc_plus4(pc_plus4),
    .stall(stall), .pc_src(pc_src), .jump(jump), .jr(jr),
    .jr_target(jr_target), .retired_count(retired_count)
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(w_rst_n),
    .imem_addr(w_addr), .imem_req(w_req),
    .imem_rdata(32'h0000_0000), .imem_ready(1'b1),
    .inst(w_inst), .inst_valid(w_valid), .pc_plus4(w_pc_plus4),
    .stall(1'b0), .pc_src(1'b0), .jump(1'b0), .jr(1'b0),
    .jr_target(32'h0000_0000), .retired_count(w_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for the request, checks its address against the scoreboard, holds
  // off 'waits' cycles, then returns 'word' and checks the capture.
  task automatic do_fetch(input logic [31:0] word, input int waits);
    for (int i = 0; i < 20 && !imem_req; i++) step();
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    if (exp_addr_q.size() == 0) begin
      chk("addr_q_empty", 32'd0, 32'd1);
      cur_pc = imem_addr;
    end else begin
      cur_pc = exp_addr_q.pop_front();
      chk("fetch_addr", imem_addr, cur_pc);
    end
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0;
      step();
      chk("wait_addr", imem_addr, cur_pc);
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_valid", {31'd0, inst_valid}, 32'd0);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    exp_inst_q.push_back(word);
    step();
    imem_ready = 1'b0;
    imem_rdata = 32'hBAD0_BAD0;
    chk("cap_valid", {31'd0, inst_valid}, 32'd1);
    chk("cap_req", {31'd0, imem_req}, 32'd0);
    cur_inst = exp_inst_q.pop_front();
    chk("cap_inst", inst, cur_inst);
    chk("pc_plus4", pc_plus4, cur_pc + 32'd4);
  endtask

  task automatic do_retire(input int stalls, input logic s_src, input logic s_jump,
                           input logic s_jr, input logic [31:0] tgt, input logic [31:0] exp_next);
    for (int i = 0; i < stalls; i++) begin
      stall = 1'b1;
      step();
      chk("stall_inst", inst, cur_inst);
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_count", retired_count, retired);
      chk("stall_pc4", pc_plus4, cur_pc + 32'd4);
    end
    stall     = 1'b0;
    pc_src    = s_src;
    jump      = s_jump;
    jr        = s_jr;
    jr_target = tgt;
    exp_addr_q.push_back(exp_next);
    retired++;
    step();
    pc_src    = 1'b0;
    jump      = 1'b0;
    jr        = 1'b0;
    jr_target = 32'hFFFF_FFFF;
    chk("ret_count", retired_count, retired);
    chk("ret_valid", {31'd0, inst_valid}, 32'd0);
    chk("ret_req", {31'd0, imem_req}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    w_rst_n = 1'b0;
    imem_rdata = 32'h2008_0005;
    imem_ready = 1'b1;
    stall = 1'b0;
    pc_src = 1'b0;
    jump = 1'b0;
    jr = 1'b0;
    jr_target = 32'h0;
    repeat (2) step();

    // Reset state
    chk("rst_addr", imem_addr, 32'h0000_0100);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_pc4", pc_plus4, 32'h0000_0104);
    chk("rst_count", retired_count, 32'd0);

    rst_n = 1'b1;
    #1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    exp_addr_q.push_back(32'h0000_0100);
    step();
    chk("first_req", {31'd0, imem_req}, 32'd1);

    // First fetch with zero wait states, then sequential retire
    do_fetch(32'h2008_0005, 0);
    do_retire(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0104);
    // Wait states then stall; JR with misaligned target
    do_fetch(32'h03E0_0008, 3);
    do_retire(4, 1'b0, 1'b0, 1'b1, 32'h0000_0201, 32'h0000_0200);
    // Backward branch
    do_fetch(32'h1000_FFFE, 0);
    do_retire(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_01FC);
    do_fetch(32'h03E0_0008, 0);
    do_retire(1, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0200);
    // Forward branch
    do_fetch(32'h1000_0003, 1);
    do_retire(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0210);
    // Jump
    do_fetch(32'h0800_0040, 0);
    do_retire(0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0100);
    // All three controls: jr wins
    do_fetch(32'h1000_0003, 2);
    do_retire(2, 1'b1, 1'b1, 1'b1, 32'h0000_0ABF, 32'h0000_0ABC);

    // Async reset while the request at 0xABC is pending
    chk("pre_rst_addr", imem_addr, exp_addr_q.pop_front());
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_valid", {31'd0, inst_valid}, 32'd0);
    chk("arst_count", retired_count, 32'd0);
    chk("arst_addr", imem_addr, 32'h0000_0100);
    retired = 0;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    repeat (2) step();
    imem_ready = 1'b0;
    chk("arst_inst", inst, 32'd0);
    chk("arst_valid2", {31'd0, inst_valid}, 32'd0);
    rst_n = 1'b1;
    exp_addr_q.push_back(32'h0000_0100);
    step();
    do_fetch(32'h2008_0005, 0);

    // Wrap instance
    chk("w_rst_pc4", w_pc_plus4, 32'h0000_0000);
    chk("w_rst_addr", w_addr, 32'hFFFF_FFFC);
    chk("w_rst_req", {31'd0, w_req}, 32'd0);
    w_rst_n = 1'b1;
    step();
    chk("w_req1", {31'd0, w_req}, 32'd1);
    chk("w_addr1", w_addr, 32'hFFFF_FFFC);
    step();
    chk("w_req0", {31'd0, w_req}, 32'd0);
    chk("w_valid", {31'd0, w_valid}, 32'd1);
    step();
    chk("w_req2", {31'd0, w_req}, 32'd1);
    chk("w_addr_wrap", w_addr, 32'h0000_0000);
    chk("w_count", w_count, 32'd1);
    chk("w_pc4", w_pc_plus4, 32'h0000_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
